gpu_activity_monitor: RTL and testbench
=======================================

Name: gpu_activity_monitor

Overview:
Parametrised activity and utilisation monitor for the GPU core. It replaces the flat per-cycle status packing with windowed counters for shader, ray-tracing and texture-unit occupancy, cache-miss events and peak thread count. It sits beside the unit arrays in the core top. It feeds the host status word and the power manager, which uses the utilisation alarm for DVFS decisions.

Parameters:
NUM_SHADER_CORES, 16, number of shader busy inputs (1..64)
NUM_RAY_UNITS, 4, number of ray-unit busy inputs (1..16)
NUM_TMUS, 8, number of TMU busy inputs (1..16)
WINDOW_LOG2, 10, sampling window length is 2^WINDOW_LOG2 cycles (2..20)
CNT_W, 32, width of accumulators and snapshot registers (8..32)

Ports:
clk_2GHz  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = monitoring runs
clear  in  1  synchronous clear pulse
shader_busy  in  NUM_SHADER_CORES  per-core busy
ray_unit_busy  in  NUM_RAY_UNITS  per-RT-unit busy
tmu_busy  in  NUM_TMUS  per-TMU busy
cache_miss  in  1  one count per cycle high
active_threads  in  16  current thread count
util_thresh  in  CNT_W  shader-utilisation alarm threshold
rd_sel  in  2  snapshot select: 0 shader, 1 ray, 2 tmu, 3 miss
rd_data  out  CNT_W  selected snapshot, registered
snap_valid  out  1  one-cycle pulse when new snapshot is available
util_alarm  out  1  sticky alarm
gpu_status  out  32  summary status word, registered

Behaviour:
- Reset: all outputs 0; all accumulators and snapshots 0; window counter 0; state IDLE.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on the edge where enable = 1. Window cycle 0 is the following cycle.
  - RUN -> IDLE on the edge where enable = 0. The partial window is discarded: accumulators zeroed, snapshots retained, no snap_valid.
- Per-cycle accumulation in RUN:
  - acc_shader += popcount(shader_busy)
  - acc_ray += popcount(ray_unit_busy)
  - acc_tmu += popcount(tmu_busy)
  - acc_miss += cache_miss
  - peak = max(peak, active_threads)
  - win_cnt increments.
- Saturation: every accumulator saturates at 2^CNT_W-1 and never wraps. Snapshots inherit the saturated value.
- Window end: on the edge ending window cycle 2^WINDOW_LOG2-1:
  - each snapshot <= accumulator including that cycle's contribution;
  - peak_snap <= peak including that cycle;
  - accumulators, peak and win_cnt reset to 0, and the next window starts immediately with no bubble;
  - snap_valid = 1 for exactly the following cycle.
- Alarm: at window end, if the new shader snapshot > util_thresh (unsigned), util_alarm sets. It stays set until clear or reset; a lower later window does not clear it.
- clear (any state):
  - zeroes accumulators, snapshots, peak, peak_snap, win_cnt and util_alarm;
  - suppresses snap_valid on that cycle;
  - in RUN, the next cycle is window cycle 0.
  - If clear coincides with window end, clear wins: no snapshot, no pulse.
- rd_data: registered mux of the snapshots; follows rd_sel with 1-cycle latency. It reflects a new snapshot in the same cycle snap_valid is high.
- gpu_status, registered, 1-cycle latency from inputs:
  - bit0 = |shader_busy
  - bit1 = |ray_unit_busy
  - bit2 = |tmu_busy
  - bit3 = cache_miss
  - bit4 = util_alarm
  - bit5 = state==RUN
  - [15:6] = 0
  - [31:16] = see Optional Feature
- Busy and miss inputs are ignored in IDLE, except for gpu_status bits 0-3.

Optional Feature:
GPU_ACT_MON_PEAK_EN
- Defined: the peak/peak_snap logic is built and gpu_status[31:16] = peak_snap, the peak active_threads of the last completed window.
- Undefined: no peak registers; gpu_status[31:16] = active_threads registered one cycle.

Test Plan:
- Reset mid-RUN, accumulators nonzero -> all outputs 0 immediately; state IDLE; snapshots 0 after release.
- WINDOW_LOG2=4, enable=1, shader_busy=16'h00FF constant -> snap_valid pulses 17 cycles after the enable edge; rd_sel=0 gives 128; rd_sel=1 gives 0.
- WINDOW_LOG2=4, cache_miss high on 5 cycles of the window, tmu_busy=8'h03 for all cycles -> rd_sel=3 gives 5; rd_sel=2 gives 32.
- util_thresh=100, window with shader 0x00FF -> util_alarm=1; next window all-idle -> alarm stays 1; clear pulse -> alarm 0 and rd_data 0.
- WINDOW_LOG2=4, enable dropped at window cycle 8 -> no snap_valid, old snapshot unchanged; re-enable -> full 16-cycle window before the next pulse.
- CNT_W=8, WINDOW_LOG2=5, all 16 shaders busy -> shader snapshot 255 (saturated, not 0); with GPU_ACT_MON_PEAK_EN, active_threads peaking at 0x1234 -> gpu_status[31:16]=16'h1234 after the window.

Source files
------------

// File: rtl/gpu_activity_monitor.sv
// gpu_activity_monitor
//   Windowed activity counters for shader, ray-tracing and texture units,
//   plus cache-miss events. Each window is 2^WINDOW_LOG2 cycles. At the end of
//   a window the accumulators are captured into snapshot registers and
//   snap_valid pulses. A sticky alarm is raised when shader utilisation in a
//   window exceeds util_thresh.
//   Optional macro GPU_ACT_MON_PEAK_EN: tracks the peak active_threads per
//   window and reports it in gpu_status[31:16]. Without the macro,
//   gpu_status[31:16] is active_threads delayed by one cycle.
module gpu_activity_monitor #(
  parameter int unsigned NUM_SHADER_CORES = 16,
  parameter int unsigned NUM_RAY_UNITS    = 4,
  parameter int unsigned NUM_TMUS         = 8,
  parameter int unsigned WINDOW_LOG2      = 10,
  parameter int unsigned CNT_W            = 32
) (
  input  logic                        clk_2GHz,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_SHADER_CORES-1:0] shader_busy,
  input  logic [NUM_RAY_UNITS-1:0]    ray_unit_busy,
  input  logic [NUM_TMUS-1:0]         tmu_busy,
  input  logic                        cache_miss,
  input  logic [15:0]                 active_threads,
  input  logic [CNT_W-1:0]            util_thresh,
  input  logic [1:0]                  rd_sel,
  output logic [CNT_W-1:0]            rd_data,
  output logic                        snap_valid,
  output logic                        util_alarm,
  output logic [31:0]                 gpu_status
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [WINDOW_LOG2-1:0] win_cnt;

  logic [CNT_W-1:0] acc_shader, acc_ray, acc_tmu, acc_miss;
  logic [CNT_W-1:0] snap_shader, snap_ray, snap_tmu, snap_miss;
  logic [CNT_W-1:0] pc_shader, pc_ray, pc_tmu, pc_miss;
  logic [CNT_W-1:0] sum_shader, sum_ray, sum_tmu, sum_miss;
  logic [CNT_W-1:0] nx_shader, nx_ray, nx_tmu, nx_miss;
  logic [CNT_W-1:0] rd_mux;
  logic [15:0]      status_hi;

  logic accumulate;
  logic flush;
  logic window_done;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Population counts of the busy vectors, widened to accumulator width
  always_comb begin
    pc_shader = '0;
    pc_ray    = '0;
    pc_tmu    = '0;
    for (int unsigned i = 0; i < NUM_SHADER_CORES; i++)
      pc_shader = pc_shader + CNT_W'(shader_busy[i]);
    for (int unsigned i = 0; i < NUM_RAY_UNITS; i++)
      pc_ray = pc_ray + CNT_W'(ray_unit_busy[i]);
    for (int unsigned i = 0; i < NUM_TMUS; i++)
      pc_tmu = pc_tmu + CNT_W'(tmu_busy[i]);
    pc_miss = CNT_W'(cache_miss);
  end

  // Saturating accumulator updates including this cycle's contribution
  always_comb begin
    sum_shader = sat_add(acc_shader, pc_shader);
    sum_ray    = sat_add(acc_ray, pc_ray);
    sum_tmu    = sat_add(acc_tmu, pc_tmu);
    sum_miss   = sat_add(acc_miss, pc_miss);
  end

  // FSM state register
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and datapath control strobes
  always_comb begin
    state_next  = state;
    accumulate  = 1'b0;
    flush       = 1'b0;
    window_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_next = IDLE;
          flush      = 1'b1;
        end else begin
          accumulate  = 1'b1;
          window_done = (win_cnt == '1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next snapshot values; rd_data is muxed from these so it shows a new
  // snapshot in the same cycle snap_valid is raised
  always_comb begin
    nx_shader = snap_shader;
    nx_ray    = snap_ray;
    nx_tmu    = snap_tmu;
    nx_miss   = snap_miss;
    if (clear) begin
      nx_shader = '0;
      nx_ray    = '0;
      nx_tmu    = '0;
      nx_miss   = '0;
    end else if (window_done) begin
      nx_shader = sum_shader;
      nx_ray    = sum_ray;
      nx_tmu    = sum_tmu;
      nx_miss   = sum_miss;
    end
  end

  // Read-back select
  always_comb begin
    case (rd_sel)
      2'd0:    rd_mux = nx_shader;
      2'd1:    rd_mux = nx_ray;
      2'd2:    rd_mux = nx_tmu;
      default: rd_mux = nx_miss;
    endcase
  end

  // Snapshot registers and registered read port
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      snap_shader <= '0;
      snap_ray    <= '0;
      snap_tmu    <= '0;
      snap_miss   <= '0;
      rd_data     <= '0;
    end else begin
      snap_shader <= nx_shader;
      snap_ray    <= nx_ray;
      snap_tmu    <= nx_tmu;
      snap_miss   <= nx_miss;
      rd_data     <= rd_mux;
    end
  end

  // Accumulators, window counter, snapshot pulse and sticky alarm
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      acc_shader <= '0;
      acc_ray    <= '0;
      acc_tmu    <= '0;
      acc_miss   <= '0;
      win_cnt    <= '0;
      snap_valid <= 1'b0;
      util_alarm <= 1'b0;
    end else if (clear) begin
      acc_shader <= '0;
      acc_ray    <= '0;
      acc_tmu    <= '0;
      acc_miss   <= '0;
      win_cnt    <= '0;
      snap_valid <= 1'b0;
      util_alarm <= 1'b0;
    end else begin
      snap_valid <= window_done;
      if (flush) begin
        acc_shader <= '0;
        acc_ray    <= '0;
        acc_tmu    <= '0;
        acc_miss   <= '0;
        win_cnt    <= '0;
      end else if (accumulate) begin
        if (window_done) begin
          acc_shader <= '0;
          acc_ray    <= '0;
          acc_tmu    <= '0;
          acc_miss   <= '0;
          win_cnt    <= '0;
          if (sum_shader > util_thresh) util_alarm <= 1'b1;
        end else begin
          acc_shader <= sum_shader;
          acc_ray    <= sum_ray;
          acc_tmu    <= sum_tmu;
          acc_miss   <= sum_miss;
          win_cnt    <= win_cnt + 1'b1;
        end
      end
    end
  end

`ifdef GPU_ACT_MON_PEAK_EN
  logic [15:0] peak, peak_snap, peak_cur;

  // Running maximum including the current cycle
  always_comb begin
    peak_cur = (active_threads > peak) ? active_threads : peak;
  end

  // Peak tracker, captured at window end alongside the counters
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      peak      <= '0;
      peak_snap <= '0;
    end else if (clear) begin
      peak      <= '0;
      peak_snap <= '0;
    end else if (flush) begin
      peak      <= '0;
    end else if (accumulate) begin
      if (window_done) begin
        peak_snap <= peak_cur;
        peak      <= '0;
      end else begin
        peak      <= peak_cur;
      end
    end
  end

  // Status upper half reports the last completed window's peak
  always_comb begin
    status_hi = peak_snap;
  end
`else
  // Status upper half reports the live thread count
  always_comb begin
    status_hi = active_threads;
  end
`endif

  // Registered status word
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      gpu_status <= '0;
    end else begin
      gpu_status <= {status_hi, 10'b0, (state == RUN), util_alarm, cache_miss,
                     |tmu_busy, |ray_unit_busy, |shader_busy};
    end
  end

endmodule

// File: tb/tb_gpu_activity_monitor.sv
// Testbench for gpu_activity_monitor: scoreboard of expected snapshots
// checked on every snap_valid pulse, plus directed checks.
module tb_gpu_activity_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // DUT 1: 16/4/8 units, 16-cycle windows, 32-bit counters
  logic        enable = 1'b0, clear = 1'b0, cache_miss = 1'b0;
  logic [15:0] shader_busy = '0;
  logic [3:0]  ray_unit_busy = '0;
  logic [7:0]  tmu_busy = '0;
  logic [15:0] active_threads = '0;
  logic [31:0] util_thresh = 32'd1000;
  logic [1:0]  rd_sel = 2'd0;
  logic [31:0] rd_data;
  logic        snap_valid, util_alarm;
  logic [31:0] gpu_status;

  // DUT 2: 8-bit counters, 32-cycle windows
  logic        enable2 = 1'b0, clear2 = 1'b0, cache_miss2 = 1'b0;
  logic [15:0] shader_busy2 = '0;
  logic [3:0]  ray_unit_busy2 = '0;
  logic [7:0]  tmu_busy2 = '0;
  logic [15:0] active_threads2 = '0;
  logic [7:0]  util_thresh2 = 8'd200;
  logic [1:0]  rd_sel2 = 2'd0;
  logic [7:0]  rd_data2;
  logic        snap_valid2, util_alarm2;
  logic [31:0] gpu_status2;

  typedef struct {
    logic [31:0] data;
    logic        alarm;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int pulses1 = 0;
  int pulses2 = 0;

  always #5 clk = ~clk;

  gpu_activity_monitor #(
    .NUM_SHADER_CORES(16), .NUM_RAY_UNITS(4), .NUM_TMUS(8),
    .WINDOW_LOG2(4), .CNT_W(32)
  ) dut (
    .clk_2GHz(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .shader_busy(shader_busy), .ray_unit_busy(ray_unit_busy),
    .tmu_busy(tmu_busy), .cache_miss(cache_miss),
    .active_threads(active_threads), .util_thresh(util_thresh),
    .rd_sel(rd_sel), .rd_data(rd_data), .snap_valid(snap_valid),
    .util_alarm(util_alarm), .gpu_status(gpu_status)
  );

  gpu_activity_monitor #(
    .NUM_SHADER_CORES(16), .NUM_RAY_UNITS(4), .NUM_TMUS(8),
    .WINDOW_LOG2(5), .CNT_W(8)
  ) dut2 (
    .clk_2GHz(clk), .rst_n(rst_n), .enable(enable2), .clear(clear2),
    .shader_busy(shader_busy2), .ray_unit_busy(ray_unit_busy2),
    .tmu_busy(tmu_busy2), .cache_miss(cache_miss2),
    .active_threads(active_threads2), .util_thresh(util_thresh2),
    .rd_sel(rd_sel2), .rd_data(rd_data2), .snap_valid(snap_valid2),
    .util_alarm(util_alarm2), .gpu_status(gpu_status2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon1();
    exp_t e;
    forever begin
      @(negedge clk);
      if (snap_valid) begin
        pulses1++;
        if (q1.size() == 0) begin
          chk("dut1_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("dut1_snap_rd_data", rd_data, e.data);
          chk("dut1_snap_alarm", {31'd0, util_alarm}, {31'd0, e.alarm});
        end
      end
    end
  endtask

  task automatic mon2();
    exp_t e;
    forever begin
      @(negedge clk);
      if (snap_valid2) begin
        pulses2++;
        if (q2.size() == 0) begin
          chk("dut2_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q2.pop_front();
          chk("dut2_snap_rd_data", {24'd0, rd_data2}, e.data);
          chk("dut2_snap_alarm", {31'd0, util_alarm2}, {31'd0, e.alarm});
        end
      end
    end
  endtask

  // Called at a negedge right after enable was driven high in IDLE;
  // counts negedges until snap_valid is seen.
  task automatic wait_pulse(input string name, input int exp_k);
    int found;
    found = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (snap_valid) begin
        found = k;
        break;
      end
    end
    if (found == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    else            chk(name, found, exp_k);
  endtask

  task automatic push1(input logic [31:0] d, input logic a);
    exp_t e;
    e.data = d;
    e.alarm = a;
    q1.push_back(e);
  endtask

  initial begin
    exp_t e2;
    int p;
    fork
      mon1();
      mon2();
    join_none

    // Reset state
    #12;
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("reset_alarm", {31'd0, util_alarm}, 32'd0);
    chk("reset_status", gpu_status, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A: shader 0x00FF for one window -> 128, pulse 17 cycles after enable
    shader_busy = 16'h00FF;
    active_threads = 16'h0ABC;
    rd_sel = 2'd0;
    push1(32'd128, 1'b0);
    enable = 1'b1;
    repeat (5) @(negedge clk);
`ifdef GPU_ACT_MON_PEAK_EN
    chk("status_run", gpu_status, 32'h0000_0021);
`else
    chk("status_run", gpu_status, 32'h0ABC_0021);
`endif
    p = 0;
    for (int k = 6; k <= 60; k++) begin
      @(negedge clk);
      if (snap_valid) begin
        p = k;
        break;
      end
    end
    chk("a_pulse_latency", p, 32'd17);
    enable = 1'b0;
    rd_sel = 2'd1;
    @(negedge clk);
    chk("a_ray_snap", rd_data, 32'd0);
    rd_sel = 2'd0;
    @(negedge clk);
    chk("a_shader_retained", rd_data, 32'd128);

    // B: tmu 0x03 every cycle, cache_miss on 5 cycles
    shader_busy = 16'h0000;
    tmu_busy = 8'h03;
    cache_miss = 1'b0;
    rd_sel = 2'd3;
    push1(32'd5, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cache_miss = (c == 1 || c == 3 || c == 4 || c == 9 || c == 15);
    end
    @(negedge clk);
    chk("b_pulse", {31'd0, snap_valid}, 32'd1);
    enable = 1'b0;
    cache_miss = 1'b0;
    tmu_busy = 8'h00;
    rd_sel = 2'd2;
    @(negedge clk);
    chk("b_tmu_snap", rd_data, 32'd32);

    // C: alarm sets at 128 > 100, stays through an idle window, clear drops it
    util_thresh = 32'd100;
    rd_sel = 2'd0;
    shader_busy = 16'h00FF;
    push1(32'd128, 1'b1);
    push1(32'd0, 1'b1);
    enable = 1'b1;
    repeat (17) @(negedge clk);
    shader_busy = 16'h0000;
    repeat (16) @(negedge clk);
    chk("c_alarm_sticky", {31'd0, util_alarm}, 32'd1);
    clear = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    chk("c_clear_alarm", {31'd0, util_alarm}, 32'd0);
    chk("c_clear_rd_data", rd_data, 32'd0);

    // D: enable dropped at window cycle 8 discards the partial window
    shader_busy = 16'h000F;
    push1(32'd64, 1'b0);
    enable = 1'b1;
    wait_pulse("d_first_pulse", 17);
    enable = 1'b0;
    @(negedge clk);
    shader_busy = 16'hFFFF;
    enable = 1'b1;
    repeat (9) @(negedge clk);
    enable = 1'b0;
    p = pulses1;
    repeat (20) @(negedge clk);
    chk("d_no_pulse", pulses1, p);
    chk("d_snap_retained", rd_data, 32'd64);
    shader_busy = 16'h0003;
    push1(32'd32, 1'b0);
    enable = 1'b1;
    wait_pulse("d_reenable_pulse", 17);
    chk("d_post_rd_data", rd_data, 32'd32);

    // Reset mid-RUN with nonzero accumulators
    shader_busy = 16'hFFFF;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_status", gpu_status, 32'd0);
    chk("rst_alarm", {31'd0, util_alarm}, 32'd0);
    enable = 1'b0;
    shader_busy = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd_sel = s[1:0];
      @(negedge clk);
      chk("rst_snap_zero", rd_data, 32'd0);
      chk("rst_state_idle", {31'd0, gpu_status[5]}, 32'd0);
    end
    rd_sel = 2'd0;
    shader_busy = 16'h0001;
    push1(32'd16, 1'b0);
    enable = 1'b1;
    wait_pulse("rst_fresh_window", 17);

    // Clear coinciding with window end: no snapshot, no pulse
    shader_busy = 16'h00FF;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (16) @(negedge clk);
    clear = 1'b1;
    p = pulses1;
    @(negedge clk);
    clear = 1'b0;
    enable = 1'b0;
    chk("clr_win_no_pulse", {31'd0, snap_valid}, 32'd0);
    chk("clr_win_rd_data", rd_data, 32'd0);
    repeat (3) @(negedge clk);
    chk("clr_win_pulses", pulses1, p);
    chk("clr_win_alarm", {31'd0, util_alarm}, 32'd0);

    // DUT 2: 8-bit saturation (512 -> 255) and peak thread count
    shader_busy2 = 16'hFFFF;
    e2.data = 32'd255;
    e2.alarm = 1'b1;
    q2.push_back(e2);
    enable2 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      active_threads2 = (c == 10) ? 16'h1234 : 16'(c);
    end
    @(negedge clk);
    enable2 = 1'b0;
    active_threads2 = 16'h0055;
    @(negedge clk);
    chk("sat_pulses", pulses2, 32'd1);
`ifdef GPU_ACT_MON_PEAK_EN
    chk("peak_status_hi", {16'd0, gpu_status2[31:16]}, 32'h0000_1234);
`else
    chk("threads_status_hi", {16'd0, gpu_status2[31:16]}, 32'h0000_0055);
`endif

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
